// File: rtl/stopwatch_timer.sv
// Seconds stopwatch / countdown timer with programmable wrap modulus, preset load,
// lap capture and a sticky expiry flag. Commands are taken from an active-low button
// bus and fire on release.
// Optional feature: define STOPWATCH_LAP_EN to build the lap register and LAP command;
// without it lap_value is tied to 0 and the LAP button bit is ignored.
module stopwatch_timer #(
  parameter int unsigned CLK_HZ = 12000000,
  parameter int unsigned MOD    = 3600,
  parameter int unsigned W      = 14,
  parameter int unsigned BTN_W  = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [BTN_W-1:0] i_btn,
  input  logic             i_dir,
  input  logic [W-1:0]     i_preset,
  output logic [W-1:0]     o_time_value,
  output logic [W-1:0]     o_lap_value,
  output logic             o_running,
  output logic             o_expired
);

  localparam int unsigned TW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_HZ - 1);
  localparam logic [W-1:0]  TIME_LAST = W'(MOD - 1);

`ifdef STOPWATCH_LAP_EN
  localparam int unsigned NCMD = 4;
`else
  localparam int unsigned NCMD = 3;
`endif

  typedef enum logic [0:0] {StPause, StRun} state_e;

  state_e          r_state;
  logic [TW-1:0]   r_tick;
  logic [W-1:0]    r_time;
  logic            r_expired;
  // Only the command bits are remembered; higher button bits only matter for release.
  logic [NCMD-1:0] r_btn_q;

  logic [NCMD-1:0] w_low;
  logic            w_one_low;
  logic            w_fire;
  logic            w_start;
  logic            w_pause;
  logic            w_clear;
  logic [W-1:0]    w_preset_sat;

  assign w_low        = ~r_btn_q;
  assign w_one_low    = (w_low != '0) && ((w_low & (w_low - NCMD'(1))) == '0);
  assign w_fire       = (&i_btn) && w_one_low;
  assign w_start      = w_fire && w_low[0];
  assign w_pause      = w_fire && w_low[1];
  assign w_clear      = w_fire && w_low[2];
  assign w_preset_sat = (i_preset > TIME_LAST) ? TIME_LAST : i_preset;

  // Run/pause FSM, tick prescaler and seconds counter; commands take priority over a tick.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= StPause;
      r_tick    <= '0;
      r_time    <= '0;
      r_expired <= 1'b0;
      r_btn_q   <= '1;
    end else if (i_en) begin
      r_btn_q <= i_btn[NCMD-1:0];
      if (w_clear) begin
        r_state   <= StPause;
        r_tick    <= '0;
        r_expired <= 1'b0;
        r_time    <= i_dir ? w_preset_sat : '0;
      end else if (w_start && (r_state == StPause) && !(i_dir && (r_time == '0))) begin
        r_state   <= StRun;
        r_expired <= 1'b0;
      end else if (w_pause && (r_state == StRun)) begin
        // Prescaler holds so the partial second survives the pause.
        r_state <= StPause;
      end else if (r_state == StRun) begin
        if (r_tick == TICK_LAST) begin
          r_tick <= '0;
          if (!i_dir) begin
            r_time <= (r_time == TIME_LAST) ? '0 : r_time + W'(1);
          end else if (r_time <= W'(1)) begin
            // Reaching zero stops the countdown; never wraps below zero.
            r_time    <= '0;
            r_state   <= StPause;
            r_expired <= 1'b1;
          end else begin
            r_time <= r_time - W'(1);
          end
        end else begin
          r_tick <= r_tick + TW'(1);
        end
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [W-1:0] r_lap;
  logic         w_lap;

  assign w_lap = w_fire && w_low[3];

  // Lap capture takes the pre-tick value when LAP and a tick share an edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lap <= '0;
    end else if (i_en && w_lap) begin
      r_lap <= r_time;
    end
  end

  assign o_lap_value = r_lap;
`else
  assign o_lap_value = '0;
`endif

  assign o_time_value = r_time;
  assign o_running    = (r_state == StRun);
  assign o_expired    = r_expired;

endmodule

// File: tb/tb_stopwatch_timer.sv
// Directed bench for stopwatch_timer (CLK_HZ=2, MOD=3600) with a behavioural model
// checked every cycle plus hand-computed literal expectations.
module tb_stopwatch_timer;

  localparam int CLK_HZ = 2;
  localparam int MOD    = 3600;
  localparam int W      = 14;
  localparam int BTN_W  = 8;
`ifdef STOPWATCH_LAP_EN
  localparam int NCMD   = 4;
  localparam int LAP_EXP = 5;
`else
  localparam int NCMD   = 3;
  localparam int LAP_EXP = 0;
`endif

  logic             clk;
  logic             rst;
  logic             en;
  logic [BTN_W-1:0] btn;
  logic             dir;
  logic [W-1:0]     preset;
  logic [W-1:0]     time_v;
  logic [W-1:0]     lap_v;
  logic             running;
  logic             expired;

  stopwatch_timer #(
    .CLK_HZ(CLK_HZ),
    .MOD   (MOD),
    .W     (W),
    .BTN_W (BTN_W)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_btn       (btn),
    .i_dir       (dir),
    .i_preset    (preset),
    .o_time_value(time_v),
    .o_lap_value (lap_v),
    .o_running   (running),
    .o_expired   (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_on  = 1'b0;

  // Model state in plain integers.
  int               m_time;
  int               m_lap;
  int               m_phase;
  bit               m_run;
  bit               m_exp;
  logic [BTN_W-1:0] m_prev;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_time  = 0;
    m_lap   = 0;
    m_phase = 0;
    m_run   = 1'b0;
    m_exp   = 1'b0;
    m_prev  = '1;
  endtask

  // One rising edge of the reference behaviour.
  task automatic model_edge();
    int lows;
    bit fire, s, p, c, l, eff;
    if (!en) return;
    lows = 0;
    for (int k = 0; k < NCMD; k++) if (!m_prev[k]) lows++;
    fire = (btn == '1) && (lows == 1);
    s = fire && !m_prev[0];
    p = fire && !m_prev[1];
    c = fire && !m_prev[2];
    l = fire && (NCMD == 4) && !m_prev[3];
    m_prev = btn;
    if (l) m_lap = m_time;
    eff = 1'b0;
    if (c) begin
      m_run   = 1'b0;
      m_phase = 0;
      m_exp   = 1'b0;
      m_time  = dir ? ((int'(preset) > MOD - 1) ? MOD - 1 : int'(preset)) : 0;
      eff     = 1'b1;
    end else if (s && !m_run && !(dir && m_time == 0)) begin
      m_run = 1'b1;
      m_exp = 1'b0;
      eff   = 1'b1;
    end else if (p && m_run) begin
      m_run = 1'b0;
      eff   = 1'b1;
    end
    if (!eff && m_run) begin
      m_phase = (m_phase + 1) % CLK_HZ;
      if (m_phase == 0) begin
        if (!dir) begin
          m_time = (m_time + 1) % MOD;
        end else begin
          m_time = (m_time > 0) ? m_time - 1 : 0;
          if (m_time == 0) begin
            m_run = 1'b0;
            m_exp = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic tick_clk(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
    end
  endtask

  task automatic press(input logic [BTN_W-1:0] pattern);
    btn = pattern;
    tick_clk(1);
    btn = '1;
    tick_clk(1);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("model time_value", int'(time_v), m_time);
      check("model lap_value", int'(lap_v), m_lap);
      check("model running", int'(running), int'(m_run));
      check("model expired", int'(expired), int'(m_exp));
    end
  end

  initial begin
    rst    = 1'b1;
    en     = 1'b1;
    dir    = 1'b0;
    btn    = '1;
    preset = '0;
    model_reset();
    #2;
    check("reset time_value", int'(time_v), 0);
    check("reset lap_value", int'(lap_v), 0);
    check("reset running", int'(running), 0);
    check("reset expired", int'(expired), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_on = 1'b1;

    // Count up: 20 cycles is 10 seconds.
    press(8'hFE);
    check("start running", int'(running), 1);
    tick_clk(20);
    check("up 20 cycles", int'(time_v), 10);
    check("up no expiry", int'(expired), 0);

    // Wrap at MOD-1 and partial-second retention across pause.
    press(8'hFB);
    check("clear up time", int'(time_v), 0);
    press(8'hFE);
    tick_clk(7198);
    check("reach 3599", int'(time_v), 3599);
    tick_clk(2);
    check("wrap to 0", int'(time_v), 0);
    press(8'hFD);
    check("pause running", int'(running), 0);
    tick_clk(10);
    check("paused hold", int'(time_v), 0);
    press(8'hFE);
    check("resume no tick yet", int'(time_v), 0);
    tick_clk(1);
    check("partial second tick", int'(time_v), 1);

    // Countdown from preset 3.
    dir    = 1'b1;
    preset = 14'd3;
    press(8'hFB);
    check("clear loads preset", int'(time_v), 3);
    press(8'hFE);
    tick_clk(2);
    check("down 2", int'(time_v), 2);
    tick_clk(2);
    check("down 1", int'(time_v), 1);
    tick_clk(2);
    check("down 0", int'(time_v), 0);
    check("expire stops", int'(running), 0);
    check("expired set", int'(expired), 1);
    press(8'hFE);
    check("start at 0 ignored", int'(running), 0);
    check("expired sticky", int'(expired), 1);
    press(8'hFB);
    check("clear expired", int'(expired), 0);
    check("clear reload", int'(time_v), 3);
    preset = 14'd5000;
    press(8'hFB);
    check("preset clamp", int'(time_v), 3599);
    preset = 14'd3;
    press(8'hFB);
    dir = 1'b0;

    // Two buttons at once are ignored; LAP on a tick edge captures the pre-tick value.
    press(8'hFC);
    check("multi press ignored", int'(running), 0);
    check("multi press time", int'(time_v), 3);
    press(8'hFE);
    tick_clk(4);
    check("up to 5", int'(time_v), 5);
    press(8'hF7);
    check("lap value", int'(lap_v), LAP_EXP);
    check("lap with tick", int'(time_v), 6);

    // Asynchronous reset between edges.
    tick_clk(1);
    rst = 1'b1;
    model_reset();
    #1;
    check("async rst time", int'(time_v), 0);
    check("async rst running", int'(running), 0);
    check("async rst lap", int'(lap_v), 0);
    #1;
    rst = 1'b0;

    // Enable low freezes everything mid-run.
    press(8'hFE);
    tick_clk(5);
    check("run before freeze", int'(time_v), 2);
    en = 1'b0;
    tick_clk(50);
    check("frozen time", int'(time_v), 2);
    check("frozen running", int'(running), 1);
    en = 1'b1;
    tick_clk(1);
    check("resume after freeze", int'(time_v), 3);

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/stopwatch_timer.md
Name: stopwatch_timer

Overview:
Parametrised successor to the single-mode seconds stopwatch. It counts seconds, up (stopwatch) or down (countdown timer), with a programmable wrap modulus, a preset load, lap capture and an expiry flag. It sits between the button scanner (active-low button bus, 12 MHz board clock) and the display formatter, which consumes time_value/lap_value as binary seconds.

Parameters:
CLK_HZ, 12000000, clk cycles per one-second tick; sim benches use 2
MOD, 3600, count modulus; time_value range 0..MOD-1
W, 14, width of time_value, lap_value, preset; must satisfy 2**W >= MOD
BTN_W, 8, width of active-low button bus; must be >= 4

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
en  in  1  block enable; 0 freezes all state (replaces legacy mode==0 gating)
btn  in  BTN_W  active-low buttons: bit0 START, bit1 PAUSE, bit2 CLEAR, bit3 LAP; other bits ignored
dir  in  1  0 = count up, 1 = count down; sampled every tick
preset  in  W  countdown start value, loaded on CLEAR when dir=1
time_value  out  W  current seconds value, registered
lap_value  out  W  seconds captured at last LAP, registered
running  out  1  1 in RUN state
expired  out  1  sticky countdown-reached-zero flag

Behaviour:
- Reset (async, rst=1): state=PAUSE, tick counter=0, time_value=0, lap_value=0, btn_q=all ones, running=0, expired=0. Outputs take reset values immediately, not at the next edge.
- en=0: no register changes (tick counter, state, btn_q all hold); outputs hold.
- Button decode (en=1): btn_q <= btn every cycle. A command fires on release: btn == all ones AND btn_q has exactly one of bits 0..3 low. Multi-bit-low patterns in btn_q are ignored. Action is visible on the outputs 1 cycle after the release edge.
- START: PAUSE->RUN; clears expired. Ignored in RUN. If dir=1 and time_value==0, ignored (stays PAUSE).
- PAUSE: RUN->PAUSE. Tick counter holds its value (partial second preserved).
- CLEAR: from any state -> PAUSE; tick counter=0; expired=0; time_value = (dir ? min(preset, MOD-1) : 0). lap_value unchanged.
- LAP: lap_value <= time_value as seen at that edge. Allowed in RUN and PAUSE; state unchanged.
- Tick: in RUN, tick counter counts 0..CLK_HZ-1. On the cycle it equals CLK_HZ-1, it wraps to 0 and a tick occurs. Exactly CLK_HZ cycles per second; no off-by-one.
- Up tick: time_value = (time_value==MOD-1) ? 0 : time_value+1. Wrap is silent.
- Down tick: time_value-1. When the result is 0: state->PAUSE, expired=1, tick counter=0, same cycle. No wrap below 0.
- Simultaneous command and tick on the same edge: the command wins and the tick is dropped. Exception: LAP with a tick applies both, and lap_value gets the pre-tick value.
- dir change mid-RUN applies from the next tick; time_value is not modified.
- running = (state==RUN), registered.

Optional Feature:
STOPWATCH_LAP_EN
- Defined: lap register and LAP command exist as specified.
- Undefined: no lap register is synthesised; lap_value is constant 0; the LAP button pattern is ignored like any other unused bit.

Test Plan:
- CLK_HZ=2, MOD=3600, dir=0: reset, release START, run 20 cycles -> running=1, time_value=10 exactly; expired=0.
- Same config: time_value forced via 7198 cycles of run to 3599, 2 more cycles -> time_value=0; then PAUSE, hold 10 cycles, START, 1 cycle -> no tick until the remaining partial-second cycle completes.
- dir=1, preset=3, CLEAR then START, 6 cycles -> time_value 3,2,1,0; running=0, expired=1 at the 0 edge. Further START with time_value=0 is ignored. CLEAR -> expired=0, time_value=3.
- Press btn=8'b11111100 (START+PAUSE together) then release -> no state change. Press LAP at time_value=5 on a tick edge -> lap_value=5, time_value=6.
- Assert rst mid-RUN between clock edges -> outputs 0 before the next edge. With en=0 for 50 cycles mid-RUN -> time_value unchanged, then it resumes.
- Build without STOPWATCH_LAP_EN: LAP release -> lap_value stays 0; all other scenarios pass unchanged.
